dmg_reg_trace: RTL and testbench
================================

# dmg_reg_trace

Parametrised register-trace capture block for the DMG simulation and bring-up harness. It samples a multi-channel snapshot (e.g. AF/BC/DE/HL/SP/PC/ZW) on every instruction-boundary strobe into a circular buffer. It supports a value-match trigger with programmable post-trigger depth and random-access readout. It sits beside `dmg_main`, replacing ad-hoc waveform dumping with a synthesizable, bounded trace usable in simulation and on FPGA.

## Interface
- `CHANNELS`, 7: number of snapshot channels.
- `WIDTH`, 16: bits per channel.
- `DEPTH`, 64: buffer entries; power of two, ≥ 4.
- `TRIG_CH`, 5: channel index compared against `trig_value`.
- `AW`, $clog2(DEPTH): derived address width.
- `CW`, $clog2(CHANNELS+1): derived channel-select width.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `snap_valid`  in  1  sample strobe, one cycle per snapshot.
- `snap_data`  in  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
- `arm`  in  1  pulse: clear trace and start capture.
- `stop`  in  1  pulse: end capture immediately.
- `trig_en`  in  1  enable value-match trigger.
- `trig_value`  in  WIDTH  match value for channel `TRIG_CH`.
- `post_count`  in  AW  samples to capture after the trigger sample (0..DEPTH-1).
- `rd_addr`  in  AW  read index; 0 = oldest retained sample.
- `rd_chan`  in  CW  channel to read; `CHANNELS` selects the timestamp.
- `rd_data`  out  WIDTH  registered read data.
- `state`  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- `sample_count`  out  AW+1  valid entries (0..DEPTH).
- `triggered`  out  1  trigger has fired since the last arm.
- `trig_pos`  out  AW  index (oldest-relative) of the trigger sample.

## Operation
- IDLE: `snap_valid` ignored. `arm` → ARMED, with `wr_ptr`=0, `sample_count`=0, `triggered`=0.
- ARMED: each `snap_valid` writes `snap_data` at `wr_ptr`. `wr_ptr` wraps mod DEPTH; `sample_count` saturates at DEPTH, overwriting the oldest entry.
- Trigger: in ARMED with `trig_en`=1, a `snap_valid` whose channel `TRIG_CH` equals `trig_value` is written normally, then:
  - `triggered`←1 and `trig_pos`←(post-write count − 1);
  - → POST with remaining=`post_count`, latched at that edge;
  - if `post_count`=0, → DONE directly.
- POST: each `snap_valid` writes and decrements remaining. The write that brings remaining to 0 → DONE. Each write made while count=DEPTH decrements `trig_pos`, which cannot underflow since `post_count` ≤ DEPTH-1.
- `trig_en`=0: ARMED never triggers; capture runs until `stop`.
- `stop` in ARMED or POST → DONE. In IDLE or DONE, `stop` is ignored.
- DONE: `snap_valid` ignored; contents frozen. `arm` re-arms.
- Priority within one cycle: `arm` > `stop` > `snap_valid`.
  - `arm`+`snap_valid`: the sample is discarded and the buffer cleared.
  - `stop`+`snap_valid`: the sample is written, including any trigger evaluation, then → DONE.
- Readout: physical index = (`wr_ptr` − `sample_count` + `rd_addr`) mod DEPTH.
  - `rd_addr` ≥ `sample_count` returns 0.
  - `rd_chan` > `CHANNELS` returns 0.
  - Reads are legal in every state; reads during capture return the current contents.
- Reset mid-operation: → IDLE, all counters cleared. RAM contents are not cleared, but none are visible because `sample_count`=0.

## Timing
- Reset values: `state`=0, `sample_count`=0, `triggered`=0, `trig_pos`=0, `rd_data`=0.
- A write is visible to readout on the cycle after its `snap_valid` edge.
- `rd_data` has 1-cycle latency from `rd_addr`/`rd_chan`.
- State transitions occur on the edge where the qualifying input is sampled. `state` reflects the new state the following cycle.
- Back-to-back `snap_valid` every cycle is supported with no loss.

## Configuration
- `DMG_TRACE_TIMESTAMP_EN` defined:
  - a WIDTH-bit cycle counter clears on `arm` and saturates at all-ones;
  - each entry stores the counter value at its write;
  - `rd_chan`=`CHANNELS` returns that stamp.
- Undefined: no counter or stamp storage is built, and `rd_chan`=`CHANNELS` returns 0.

## Test plan
Bench parameters: DEPTH=8, CHANNELS=7, WIDTH=16, TRIG_CH=5.
- Reset: hold `rst`=0 for 1 cycle mid-capture → `state`=0, `sample_count`=0, `triggered`=0; `rd_data`=0 for every `rd_addr`.
- Free-run: arm, `trig_en`=0, 5 snaps with PC 0x0100..0x0104, then stop → DONE, count=5. `rd_addr`=0, chan 5 reads 0x0100 one cycle later; `rd_addr`=5 reads 0.
- Wrap: arm, 12 snaps with PC 0..11, stop → count=8, `rd_addr` 0 → 4, `rd_addr` 7 → 11.
- Trigger: `trig_value`=0x0150, `post_count`=3, 30 snaps with PC 0x0140 upward → DONE after 0x0153, `triggered`=1, `trig_pos`=4, `rd_addr` 0 → 0x014C, `rd_addr` 7 → 0x0153. Later snaps leave contents unchanged.
- Edge cases:
  - `post_count`=0, trigger on the 3rd snap → DONE on that edge, `trig_pos`=2.
  - `arm`+`snap_valid` same cycle → count=0.
  - `stop`+`snap_valid` same cycle → sample stored, DONE.
- Timestamp (macro defined): arm, 3 snaps on cycles 2, 5, 9 after arm → `rd_chan`=7 reads 2, 5, 9. Without the macro it reads 0.

Source files
------------

// File: rtl/dmg_reg_trace.sv
// dmg_reg_trace: register-trace capture for the DMG bring-up harness.
// Each snap_valid strobe stores a multi-channel snapshot in a circular buffer.
// A value-match trigger with programmable post-trigger depth is supported,
// and any retained sample can be read back through a registered port.
// Optional feature macro: DMG_TRACE_TIMESTAMP_EN adds a per-entry cycle stamp,
// which is read back on rd_chan == CHANNELS.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | out of reset, snapshots ignored
// ARMED   | capturing, waiting for trigger or stop
// POST    | trigger seen, capturing post-trigger samples
// DONE    | capture finished, contents frozen
module dmg_reg_trace #(
  parameter int CHANNELS = 7,
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 64,
  parameter int TRIG_CH  = 5,
  parameter int AW       = $clog2(DEPTH),
  parameter int CW       = $clog2(CHANNELS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      snap_valid,
  input  logic [CHANNELS*WIDTH-1:0] snap_data,
  input  logic                      arm,
  input  logic                      stop,
  input  logic                      trig_en,
  input  logic [WIDTH-1:0]          trig_value,
  input  logic [AW-1:0]             post_count,
  input  logic [AW-1:0]             rd_addr,
  input  logic [CW-1:0]             rd_chan,
  output logic [WIDTH-1:0]          rd_data,
  output logic [1:0]                state,
  output logic [AW:0]               sample_count,
  output logic                      triggered,
  output logic [AW-1:0]             trig_pos
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } st_t;

  st_t                      st;
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            remaining;
  logic [AW:0]              count_q;
  logic                     triggered_q;
  logic [AW-1:0]            trig_pos_q;
  logic [CHANNELS*WIDTH-1:0] mem [DEPTH];

  logic                     capturing;
  logic                     wr_en;
  logic                     full;
  logic [AW:0]              count_inc;
  logic                     trig_hit;

  // write qualification and saturating count helpers
  always_comb begin
    capturing = (st == S_ARMED) || (st == S_POST);
    wr_en     = rst && !arm && snap_valid && capturing;
    full      = (count_q == (AW+1)'(DEPTH));
    count_inc = full ? count_q : count_q + 1'b1;
    trig_hit  = trig_en && (snap_data[TRIG_CH*WIDTH +: WIDTH] == trig_value);
  end

  // capture control FSM; arm beats stop beats snap_valid
  always_ff @(posedge clk) begin
    if (!rst) begin
      st          <= S_IDLE;
      wr_ptr      <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
      trig_pos_q  <= '0;
      remaining   <= '0;
    end else if (arm) begin
      st          <= S_ARMED;
      wr_ptr      <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
      trig_pos_q  <= '0;
      remaining   <= '0;
    end else begin
      case (st)
        S_ARMED: begin
          if (snap_valid) begin
            wr_ptr  <= wr_ptr + 1'b1;
            count_q <= count_inc;
            if (trig_hit) begin
              triggered_q <= 1'b1;
              trig_pos_q  <= AW'(count_inc - 1'b1);
              remaining   <= post_count;
              if (post_count == '0) st <= S_DONE;
              else                  st <= S_POST;
            end
          end
          if (stop) st <= S_DONE;
        end
        S_POST: begin
          if (snap_valid) begin
            wr_ptr    <= wr_ptr + 1'b1;
            count_q   <= count_inc;
            // overwriting the oldest entry shifts the trigger one slot older
            if (full) trig_pos_q <= trig_pos_q - 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == AW'(1)) st <= S_DONE;
          end
          if (stop) st <= S_DONE;
        end
        default: ;
      endcase
    end
  end

  // snapshot storage, not reset; visibility is gated by count_q
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= snap_data;
  end

`ifdef DMG_TRACE_TIMESTAMP_EN
  logic [WIDTH-1:0] ts_cnt;
  logic [WIDTH-1:0] ts_next;
  logic [WIDTH-1:0] ts_mem [DEPTH];

  assign ts_next = (&ts_cnt) ? ts_cnt : ts_cnt + 1'b1;

  // saturating cycle counter, zeroed by arm
  always_ff @(posedge clk) begin
    if (!rst)     ts_cnt <= '0;
    else if (arm) ts_cnt <= '0;
    else          ts_cnt <= ts_next;
  end

  // stamp stored alongside each snapshot: edges elapsed since arm
  always_ff @(posedge clk) begin
    if (wr_en) ts_mem[wr_ptr] <= ts_next;
  end
`endif

  logic [AW-1:0]             phys;
  logic [CHANNELS*WIDTH-1:0] entry;
  logic [WIDTH-1:0]          rd_next;

  // oldest-relative address translation and channel select
  always_comb begin
    phys    = wr_ptr - count_q[AW-1:0] + rd_addr;
    entry   = mem[phys];
    rd_next = '0;
    if ({1'b0, rd_addr} < count_q) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (rd_chan == CW'(k)) rd_next = entry[k*WIDTH +: WIDTH];
      end
`ifdef DMG_TRACE_TIMESTAMP_EN
      if (rd_chan == CW'(CHANNELS)) rd_next = ts_mem[phys];
`endif
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= rd_next;
  end

  assign state        = st;
  assign sample_count = count_q;
  assign triggered    = triggered_q;
  assign trig_pos     = trig_pos_q;

endmodule

// File: tb/tb_dmg_reg_trace.sv
// Directed bench for dmg_reg_trace with DEPTH=8, CHANNELS=7, WIDTH=16, TRIG_CH=5.
module tb_dmg_reg_trace;
  localparam int CHANNELS = 7;
  localparam int WIDTH    = 16;
  localparam int DEPTH    = 8;
  localparam int TRIG_CH  = 5;
  localparam int AW       = 3;
  localparam int CW       = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      snap_valid;
  logic [CHANNELS*WIDTH-1:0] snap_data;
  logic                      arm;
  logic                      stop;
  logic                      trig_en;
  logic [WIDTH-1:0]          trig_value;
  logic [AW-1:0]             post_count;
  logic [AW-1:0]             rd_addr;
  logic [CW-1:0]             rd_chan;
  logic [WIDTH-1:0]          rd_data;
  logic [1:0]                state;
  logic [AW:0]               sample_count;
  logic                      triggered;
  logic [AW-1:0]             trig_pos;

  int checks = 0;
  int errors = 0;

  dmg_reg_trace #(
    .CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEPTH(DEPTH), .TRIG_CH(TRIG_CH)
  ) dut (
    .clk(clk), .rst(rst), .snap_valid(snap_valid), .snap_data(snap_data),
    .arm(arm), .stop(stop), .trig_en(trig_en), .trig_value(trig_value),
    .post_count(post_count), .rd_addr(rd_addr), .rd_chan(rd_chan),
    .rd_data(rd_data), .state(state), .sample_count(sample_count),
    .triggered(triggered), .trig_pos(trig_pos)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_snap(input logic [15:0] pc);
    for (int k = 0; k < CHANNELS; k++) snap_data[k*WIDTH +: WIDTH] = 16'(k);
    snap_data[0*WIDTH +: WIDTH]       = pc ^ 16'hA5A5;
    snap_data[TRIG_CH*WIDTH +: WIDTH] = pc;
  endtask

  task automatic snap(input logic [15:0] pc);
    set_snap(pc);
    snap_valid = 1'b1;
    tick();
    snap_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [CW-1:0] c,
                    input logic [15:0] exp);
    rd_addr = a; rd_chan = c;
    tick();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    logic [15:0] ts_exp [3];
    rst = 1'b0; snap_valid = 1'b0; snap_data = '0; arm = 1'b0; stop = 1'b0;
    trig_en = 1'b0; trig_value = '0; post_count = '0; rd_addr = '0; rd_chan = 3'd5;
    tick(); tick();
    check("rst_state", 32'(state), 0);
    check("rst_count", 32'(sample_count), 0);
    check("rst_trig", 32'(triggered), 0);
    check("rst_tpos", 32'(trig_pos), 0);
    check("rst_rdata", 32'(rd_data), 0);
    rst = 1'b1;

    // free-run, no trigger
    pulse_arm();
    check("arm_state", 32'(state), 1);
    for (int i = 0; i < 5; i++) snap(16'h0100 + 16'(i));
    pulse_stop();
    check("fr_state", 32'(state), 3);
    check("fr_count", 32'(sample_count), 5);
    rd("fr_rd0", 3'd0, 3'd5, 16'h0100);
    rd("fr_rd4", 3'd4, 3'd5, 16'h0104);
    rd("fr_rd0_ch0", 3'd0, 3'd0, 16'h0100 ^ 16'hA5A5);
    rd("fr_rd2_ch3", 3'd2, 3'd3, 16'h0003);
    rd("fr_rd5", 3'd5, 3'd5, 16'h0000);
    snap(16'h0999);
    check("done_ignore_snap", 32'(sample_count), 5);
    pulse_stop();
    check("done_ignore_stop", 32'(state), 3);

    // reset in the middle of a capture
    pulse_arm();
    for (int i = 0; i < 3; i++) snap(16'h0200 + 16'(i));
    rst = 1'b0; tick(); rst = 1'b1;
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_count", 32'(sample_count), 0);
    check("mid_rst_trig", 32'(triggered), 0);
    for (int a = 0; a < DEPTH; a++) rd("mid_rst_rd", 3'(a), 3'd5, 16'h0000);
    snap(16'h0300);
    check("idle_ignore_snap", 32'(sample_count), 0);

    // wraparound
    pulse_arm();
    for (int i = 0; i < 12; i++) snap(16'(i));
    pulse_stop();
    check("wrap_count", 32'(sample_count), 8);
    rd("wrap_rd0", 3'd0, 3'd5, 16'd4);
    rd("wrap_rd7", 3'd7, 3'd5, 16'd11);
    rd("wrap_rd3", 3'd3, 3'd5, 16'd7);

    // value-match trigger with post_count=3, snaps back-to-back
    trig_en = 1'b1; trig_value = 16'h0150; post_count = 3'd3;
    pulse_arm();
    set_snap(16'h0140);
    snap_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      set_snap(16'h0140 + 16'(i));
      tick();
      if (i == 15) check("trg_pre_state", 32'(state), 1);
      if (i == 16) begin
        check("trg_post_state", 32'(state), 2);
        check("trg_flag", 32'(triggered), 1);
        check("trg_pos_at_fire", 32'(trig_pos), 7);
      end
      if (i == 19) check("trg_done_state", 32'(state), 3);
    end
    snap_valid = 1'b0;
    check("trg_pos", 32'(trig_pos), 4);
    check("trg_count", 32'(sample_count), 8);
    rd("trg_rd0", 3'd0, 3'd5, 16'h014C);
    rd("trg_rd7", 3'd7, 3'd5, 16'h0153);
    rd("trg_rd4", 3'd4, 3'd5, 16'h0150);

    // post_count=0: trigger on the third snap goes straight to DONE
    trig_value = 16'h0003; post_count = 3'd0;
    pulse_arm();
    check("rearm_trig_clr", 32'(triggered), 0);
    snap(16'h0001);
    snap(16'h0002);
    snap(16'h0003);
    check("pc0_state", 32'(state), 3);
    check("pc0_tpos", 32'(trig_pos), 2);
    check("pc0_trig", 32'(triggered), 1);
    snap(16'h0004);
    check("pc0_frozen", 32'(sample_count), 3);
    trig_en = 1'b0;

    // arm with a simultaneous snap discards the sample
    set_snap(16'h0777);
    arm = 1'b1; snap_valid = 1'b1; tick(); arm = 1'b0; snap_valid = 1'b0;
    check("armsnap_state", 32'(state), 1);
    check("armsnap_count", 32'(sample_count), 0);

    // stop with a simultaneous snap stores the sample
    set_snap(16'h0888);
    stop = 1'b1; snap_valid = 1'b1; tick(); stop = 1'b0; snap_valid = 1'b0;
    check("stopsnap_state", 32'(state), 3);
    check("stopsnap_count", 32'(sample_count), 1);
    rd("stopsnap_rd0", 3'd0, 3'd5, 16'h0888);

    // timestamps: snaps on edges 2, 5 and 9 after the arm edge
`ifdef DMG_TRACE_TIMESTAMP_EN
    ts_exp[0] = 16'd2; ts_exp[1] = 16'd5; ts_exp[2] = 16'd9;
`else
    ts_exp[0] = 16'd0; ts_exp[1] = 16'd0; ts_exp[2] = 16'd0;
`endif
    pulse_arm();
    tick();
    snap(16'h0A00);
    tick(); tick();
    snap(16'h0A01);
    tick(); tick(); tick();
    snap(16'h0A02);
    pulse_stop();
    check("ts_count", 32'(sample_count), 3);
    rd("ts_rd0", 3'd0, 3'd7, ts_exp[0]);
    rd("ts_rd1", 3'd1, 3'd7, ts_exp[1]);
    rd("ts_rd2", 3'd2, 3'd7, ts_exp[2]);
    rd("ts_rd3", 3'd3, 3'd7, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
